// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signal bundle for ram_arbiter.
interface ram_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_ena;
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output ram_ena, ram_read, ram_write, ram_addr, ram_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  ram_ena, ram_read, ram_write, ram_addr, ram_wdata
    );

endinterface

// File: rtl/arb_rr_sel.sv
// Combinational 2-way winner select. RAM_ARB_CPU_PRIO_EN selects fixed port-0
// priority; otherwise the port not served last wins contention.
module arb_rr_sel
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1) begin
`ifdef RAM_ARB_CPU_PRIO_EN
            winner = PORT_CPU;
`else
            winner = (last == PORT_CPU) ? PORT_DBG : PORT_CPU;
`endif
        end else if (req1) begin
            winner = PORT_DBG;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between the CPU (port 0) and debug loader (port 1).
// Define RAM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    state_e        state_q, state_d;
    logic          port_q;
    logic          last_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          winner;
    logic          any_req;

    assign any_req = bus.req0 || bus.req1;

    arb_rr_sel u_sel (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_q),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            port_q  <= PORT_CPU;
            last_q  <= PORT_DBG;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && any_req) begin
                port_q  <= winner;
                we_q    <= (winner == PORT_DBG) ? bus.we1    : bus.we0;
                addr_q  <= (winner == PORT_DBG) ? bus.addr1  : bus.addr0;
                wdata_q <= (winner == PORT_DBG) ? bus.wdata1 : bus.wdata0;
            end
            if (state_q == StResp) begin
                last_q <= port_q;
                if (!we_q) begin
                    rdata_q <= bus.ram_rdata;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    logic in_access;
    logic resp_read;

    assign in_access = (state_q == StAccess);
    assign resp_read = (state_q == StResp) && !we_q;

    always_comb begin
        bus.ram_ena   = in_access;
        bus.ram_read  = in_access && !we_q;
        bus.ram_write = in_access && we_q;
        bus.ram_addr  = addr_q;
        bus.ram_wdata = wdata_q;
        bus.gnt0      = in_access && (port_q == PORT_CPU);
        bus.gnt1      = in_access && (port_q == PORT_DBG);
        bus.rvalid0   = resp_read && (port_q == PORT_CPU);
        bus.rvalid1   = resp_read && (port_q == PORT_DBG);
        // RAM data arrives during RESP; pass it straight through, then hold it.
        bus.rdata     = resp_read ? bus.ram_rdata : rdata_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level model of arbitration and RAM contents.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    ram_arbiter_if #(.AW(8), .DW(8)) bus ();

    ram_arbiter #(.AW(8), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: contents reload from seed on reset, read data one cycle late.
    logic [7:0] seed [256];
    logic [7:0] ram  [256];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed[i];
            bus.ram_rdata <= '0;
        end else begin
            if (bus.ram_ena && bus.ram_write) ram[bus.ram_addr] <= bus.ram_wdata;
            if (bus.ram_ena && bus.ram_read) bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    int         last_srv;
    logic [7:0] ref_rdata;

    function automatic int pick(input int c0, input int c1);
        if (c0 > 0 && c1 > 0) begin
`ifdef RAM_ARB_CPU_PRIO_EN
            return 0;
`else
            return (last_srv == 0) ? 1 : 0;
`endif
        end
        return (c0 > 0) ? 0 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = seed[i];
        last_srv  = 1;
        ref_rdata = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Each port issues c<p> back-to-back accesses with fixed we/addr/wdata, holding req.
    task automatic round(input int c0_in, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                         input int c1_in, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
        int         c[2];
        int         w;
        int         n;
        bit         found;
        bit         first;
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        c[0]  = c0_in;
        c[1]  = c1_in;
        first = 1'b1;
        @(negedge clk);
        bus.req0 = (c[0] > 0); bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = (c[1] > 0); bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        while (c[0] > 0 || c[1] > 0) begin
            w     = pick(c[0], c[1]);
            wr    = (w == 1) ? w1 : w0;
            a     = (w == 1) ? a1 : a0;
            d     = (w == 1) ? d1 : d0;
            found = 1'b0;
            n     = 0;
            while (!found && n < 6) begin
                @(posedge clk); #1;
                n++;
                if (bus.gnt0 || bus.gnt1) found = 1'b1;
            end
            check("gnt_seen", 32'(found), 32'd1);
            if (!found) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
                return;
            end
            check("gnt_latency", n, first ? 32'd1 : 32'd2);
            check("gnt0", 32'(bus.gnt0), 32'(w == 0));
            check("gnt1", 32'(bus.gnt1), 32'(w == 1));
            check("ram_ena", 32'(bus.ram_ena), 32'd1);
            check("ram_read", 32'(bus.ram_read), 32'(!wr));
            check("ram_write", 32'(bus.ram_write), 32'(wr));
            check("ram_addr", 32'(bus.ram_addr), 32'(a));
            if (wr) check("ram_wdata", 32'(bus.ram_wdata), 32'(d));
            @(posedge clk); #1;
            if (wr) ref_mem[a] = d;
            else    ref_rdata = ref_mem[a];
            check("resp_gnts", 32'({bus.gnt0, bus.gnt1, bus.ram_ena}), 32'd0);
            check("rvalid0", 32'(bus.rvalid0), 32'(!wr && w == 0));
            check("rvalid1", 32'(bus.rvalid1), 32'(!wr && w == 1));
            check("rdata", 32'(bus.rdata), 32'(ref_rdata));
            last_srv = w;
            c[w]--;
            first = 1'b0;
            @(negedge clk);
            if (c[w] == 0) begin
                if (w == 0) bus.req0 = 1'b0;
                else        bus.req1 = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) seed[i] = 8'($urandom);
        seed[8'h10] = 8'hA5;
        model_reset();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                                  bus.ram_ena, bus.ram_read, bus.ram_write}), 32'd0);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single read, single write, read-back
        round(1, 1'b0, 8'h10, 8'h00, 0, 1'b0, 8'h00, 8'h00);
        check("read_a5", 32'(bus.rdata), 32'h0A5);
        round(0, 1'b0, 8'h00, 8'h00, 1, 1'b1, 8'h20, 8'h3C);
        check("rdata_hold", 32'(bus.rdata), 32'h0A5);
        round(1, 1'b0, 8'h20, 8'h00, 0, 1'b0, 8'h00, 8'h00);
        check("read_3c", 32'(bus.rdata), 32'h03C);

        // Held contention: alternation, or port 0 first in priority mode
        round(4, 1'b0, 8'h30, 8'h00, 4, 1'b0, 8'h31, 8'h00);
        // Write vs read contention
        round(1, 1'b1, 8'h40, 8'h77, 1, 1'b0, 8'h40, 8'h00);
        round(1, 1'b0, 8'h41, 8'h00, 1, 1'b1, 8'h41, 8'h99);

        // Randomised rounds over a small address window so reads hit earlier writes
        for (int k = 0; k < 40; k++) begin
            int c0;
            int c1;
            c0 = int'($urandom_range(0, 2));
            c1 = int'($urandom_range(0, 2));
            if (c0 == 0 && c1 == 0) c0 = 1;
            round(c0, 1'($urandom), 8'(8'h80 + $urandom_range(0, 15)), 8'($urandom),
                  c1, 1'($urandom), 8'(8'h80 + $urandom_range(0, 15)), 8'($urandom));
        end

        // Reset in ACCESS abandons the access
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h44;
        bus.req1 = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_gnt0", 32'(bus.gnt0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_strobes", 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                                      bus.ram_ena, bus.ram_read, bus.ram_write}), 32'd0);
        check("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
        check("mid_rst_rdata", 32'(bus.rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("post_rst_quiet", 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}), 32'd0);
        // First contention after reset goes to port 0
        round(1, 1'b0, 8'h10, 8'h00, 1, 1'b0, 8'h11, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
